// File: rtl/number_analyzer_scheduler.sv
// Round-robin scheduler that shares one analyzer engine between N_REQ
// requesters. One request is in flight at a time; a wait counter bounds
// how long the engine may take before the request is answered with a
// timeout verdict. All outputs come straight from flops.
//
// Handshake: a requester holds req_valid until it sees a one-cycle req_ack;
// the scheduler then pulses eng_go once, waits for a one-cycle eng_done
// (sampled only while waiting), and answers with a one-cycle resp_valid to
// the same requester, with resp_result/resp_timeout valid alongside it.
module number_analyzer_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_number,
    output logic [N_REQ-1:0]       req_ack,
    output logic [N_REQ-1:0]       resp_valid,
    output logic                   resp_result,
    output logic                   resp_timeout,
    output logic                   eng_go,
    output logic [WIDTH-1:0]       eng_number,
    input  logic                   eng_done,
    input  logic                   eng_result,
    output logic                   busy,
    output logic [7:0]             timeout_count
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] number_q, number_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       tcount_q, tcount_d;
    logic             result_q, result_d;
    logic             tflag_q, tflag_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] respv_q, respv_d;
    logic             go_q, go_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] num_arr [N_REQ];
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW:0]      cand_sum;
    logic [IW-1:0]    cand_idx;

    // Split the flat operand bus into one word per requester
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            num_arr[i] = req_number[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starting just after the last served requester
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand_sum = {1'b0, last_grant_q} + (IW+1)'(off);
            if (cand_sum >= (IW+1)'(N_REQ)) begin
                cand_sum = cand_sum - (IW+1)'(N_REQ);
            end
            cand_idx = cand_sum[IW-1:0];
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so the registered versions line up with that state
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        number_d     = number_q;
        cnt_d        = cnt_q;
        tcount_d     = tcount_q;
        result_d     = result_q;
        tflag_d      = tflag_q;
        ack_d        = '0;
        respv_d      = '0;
        go_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    idx_d          = win_idx;
                    number_d       = num_arr[win_idx];
                    ack_d[win_idx] = 1'b1;
                    go_d           = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the last allowed cycle still counts as done
                if (eng_done) begin
                    result_d       = eng_result;
                    tflag_d        = 1'b0;
                    respv_d[idx_q] = 1'b1;
                    state_d        = S_RESPOND;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d       = 1'b0;
                    tflag_d        = 1'b1;
                    respv_d[idx_q] = 1'b1;
                    if (tcount_q != 8'hFF) begin
                        tcount_d = tcount_q + 8'd1;
                    end
                    state_d        = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESPOND: begin
                last_grant_d = idx_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= IW'(N_REQ - 1);
            idx_q        <= '0;
            number_q     <= '0;
            cnt_q        <= '0;
            tcount_q     <= '0;
            result_q     <= 1'b0;
            tflag_q      <= 1'b0;
            ack_q        <= '0;
            respv_q      <= '0;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            number_q     <= number_d;
            cnt_q        <= cnt_d;
            tcount_q     <= tcount_d;
            result_q     <= result_d;
            tflag_q      <= tflag_d;
            ack_q        <= ack_d;
            respv_q      <= respv_d;
            go_q         <= go_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ack       = ack_q;
    assign resp_valid    = respv_q;
    assign resp_result   = result_q;
    assign resp_timeout  = tflag_q;
    assign eng_go        = go_q;
    assign eng_number    = number_q;
    assign busy          = busy_q;
    assign timeout_count = tcount_q;

endmodule

// File: tb/tb_number_analyzer_scheduler.sv
// Directed bench for number_analyzer_scheduler with a short engine timeout.
module tb_number_analyzer_scheduler;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_number = '0;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   resp_valid;
    logic           resp_result;
    logic           resp_timeout;
    logic           eng_go;
    logic [W-1:0]   eng_number;
    logic           eng_done = 1'b0;
    logic           eng_result = 1'b0;
    logic           busy;
    logic [7:0]     timeout_count;

    int tests = 0;
    int fails = 0;
    int ack_pulses = 0;
    int resp_pulses = 0;
    int onehot_err = 0;

    number_analyzer_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_number    (req_number),
        .req_ack       (req_ack),
        .resp_valid    (resp_valid),
        .resp_result   (resp_result),
        .resp_timeout  (resp_timeout),
        .eng_go        (eng_go),
        .eng_number    (eng_number),
        .eng_done      (eng_done),
        .eng_result    (eng_result),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    // clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // pulse counters and one-hot monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (!reset) begin
            if (req_ack != '0) ack_pulses++;
            if (resp_valid != '0) resp_pulses++;
            if ($countones(req_ack) > 1 || $countones(resp_valid) > 1) onehot_err++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = '0;
        eng_done = 1'b0;
        eng_result = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic set_number(input int i, input logic [W-1:0] v);
        req_number[i*W +: W] = v;
    endtask

    // advance until a grant appears; ends on the ISSUE cycle
    task automatic wait_ack(output logic [N-1:0] got);
        int n;
        n = 0;
        while (req_ack == '0 && n < 30) begin
            tick;
            n++;
        end
        check("ack_wait_bound", 64'(n < 30), 64'(1));
        got = req_ack;
    endtask

    // from ISSUE: one WAIT cycle then done; ends on the RESPOND cycle
    task automatic serve(input logic res);
        tick;
        eng_done = 1'b1;
        eng_result = res;
        tick;
        eng_done = 1'b0;
    endtask

    // request from rv and let it time out; ends on the RESPOND cycle
    task automatic do_timeout(input logic [N-1:0] rv);
        logic [N-1:0] g;
        int n;
        req_valid = rv;
        wait_ack(g);
        req_valid = '0;
        n = 0;
        while (resp_valid == '0 && n < 30) begin
            tick;
            n++;
        end
        check("timeout_wait_bound", 64'(n < 30), 64'(1));
    endtask

    initial begin
        logic [N-1:0] g;
        int a0, r0, n;

        // reset state
        do_reset;
        check("rst_ack", 64'(req_ack), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_go", 64'(eng_go), 64'(0));
        check("rst_result", 64'(resp_result), 64'(0));
        check("rst_timeout", 64'(resp_timeout), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_number", 64'(eng_number), 64'(0));
        check("rst_tcount", 64'(timeout_count), 64'(0));

        // single request, engine done 5 cycles after eng_go
        a0 = ack_pulses;
        r0 = resp_pulses;
        set_number(0, 32'd13);
        req_valid = 4'b0001;
        tick;
        check("single_ack", 64'(req_ack), 64'(4'b0001));
        check("single_go", 64'(eng_go), 64'(1));
        check("single_number", 64'(eng_number), 64'(13));
        check("single_busy", 64'(busy), 64'(1));
        req_valid = '0;
        tick;
        check("single_ack_pulse", 64'(req_ack), 64'(0));
        check("single_go_pulse", 64'(eng_go), 64'(0));
        tick;
        tick;
        tick;
        check("single_no_early_resp", 64'(resp_valid), 64'(0));
        eng_done = 1'b1;
        eng_result = 1'b1;
        tick;
        eng_done = 1'b0;
        check("single_resp_valid", 64'(resp_valid), 64'(4'b0001));
        check("single_result", 64'(resp_result), 64'(1));
        check("single_timeout", 64'(resp_timeout), 64'(0));
        tick;
        check("single_resp_pulse", 64'(resp_valid), 64'(0));
        check("single_idle_busy", 64'(busy), 64'(0));
        check("single_result_hold", 64'(resp_result), 64'(1));
        check("single_ack_count", 64'(ack_pulses - a0), 64'(1));
        check("single_resp_count", 64'(resp_pulses - r0), 64'(1));

        // fairness with all requesters always requesting
        do_reset;
        for (int i = 0; i < N; i++) set_number(i, 32'(100 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_ack(g);
            check($sformatf("rr_grant_%0d", k), 64'(g), 64'(4'b0001 << (k % N)));
            check($sformatf("rr_number_%0d", k), 64'(eng_number), 64'(100 + (k % N)));
            serve(1'b0);
            check($sformatf("rr_resp_%0d", k), 64'(resp_valid), 64'(4'b0001 << (k % N)));
        end
        req_valid = '0;
        tick;

        // timeout with the engine silent; operand must not follow input changes
        do_reset;
        set_number(1, 32'd77);
        req_valid = 4'b0010;
        tick;
        check("to_ack", 64'(req_ack), 64'(4'b0010));
        req_valid = '0;
        set_number(1, 32'd99);
        tick;
        for (int i = 0; i < TO - 1; i++) tick;
        check("to_no_resp_before", 64'(resp_valid), 64'(0));
        check("to_busy_wait", 64'(busy), 64'(1));
        check("to_number_held", 64'(eng_number), 64'(77));
        tick;
        check("to_resp_valid", 64'(resp_valid), 64'(4'b0010));
        check("to_result", 64'(resp_result), 64'(0));
        check("to_flag", 64'(resp_timeout), 64'(1));
        check("to_count_1", 64'(timeout_count), 64'(1));
        tick;
        check("to_flag_hold", 64'(resp_timeout), 64'(1));

        // saturation after 300 timeouts in total
        r0 = resp_pulses;
        req_valid = 4'b0001;
        n = 0;
        while ((resp_pulses - r0) < 299 && n < 6000) begin
            tick;
            n++;
        end
        req_valid = '0;
        check("sat_bound", 64'(n < 6000), 64'(1));
        tick;
        tick;
        check("sat_resp_count", 64'(resp_pulses - r0), 64'(299));
        check("sat_count", 64'(timeout_count), 64'(255));

        // done on the final wait cycle beats the timeout
        do_reset;
        do_timeout(4'b0001);
        check("col_pre_count", 64'(timeout_count), 64'(1));
        req_valid = 4'b0100;
        wait_ack(g);
        check("col_ack", 64'(g), 64'(4'b0100));
        req_valid = '0;
        tick;
        for (int i = 0; i < TO - 1; i++) tick;
        eng_done = 1'b1;
        eng_result = 1'b1;
        tick;
        eng_done = 1'b0;
        check("col_resp_valid", 64'(resp_valid), 64'(4'b0100));
        check("col_flag", 64'(resp_timeout), 64'(0));
        check("col_result", 64'(resp_result), 64'(1));
        check("col_count", 64'(timeout_count), 64'(1));
        tick;

        // reset in the middle of WAIT
        do_reset;
        req_valid = 4'b0010;
        wait_ack(g);
        req_valid = '0;
        serve(1'b1);
        tick;
        req_valid = 4'b0100;
        wait_ack(g);
        check("rw_ack", 64'(g), 64'(4'b0100));
        req_valid = 4'b1001;
        tick;
        tick;
        r0 = resp_pulses;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rw_busy", 64'(busy), 64'(0));
        check("rw_resp", 64'(resp_valid), 64'(0));
        check("rw_number", 64'(eng_number), 64'(0));
        tick;
        check("rw_regrant", 64'(req_ack), 64'(4'b0001));
        check("rw_no_resp", 64'(resp_pulses - r0), 64'(0));
        req_valid = '0;
        serve(1'b0);
        tick;

        // stray eng_done in IDLE and ISSUE
        do_reset;
        eng_done = 1'b1;
        eng_result = 1'b1;
        tick;
        tick;
        tick;
        check("stray_idle_busy", 64'(busy), 64'(0));
        check("stray_idle_resp", 64'(resp_valid), 64'(0));
        check("stray_idle_result", 64'(resp_result), 64'(0));
        set_number(0, 32'd5);
        req_valid = 4'b0001;
        tick;
        check("stray_ack", 64'(req_ack), 64'(4'b0001));
        req_valid = '0;
        tick;
        check("stray_issue_resp", 64'(resp_valid), 64'(0));
        check("stray_issue_busy", 64'(busy), 64'(1));
        eng_done = 1'b0;
        tick;
        tick;
        check("stray_wait_resp", 64'(resp_valid), 64'(0));
        eng_done = 1'b1;
        eng_result = 1'b0;
        tick;
        eng_done = 1'b0;
        check("stray_final_resp", 64'(resp_valid), 64'(4'b0001));
        check("stray_final_flag", 64'(resp_timeout), 64'(0));
        tick;

        check("onehot", 64'(onehot_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/number_analyzer_scheduler.md
NUMBER_ANALYZER_SCHEDULER -- requirements
Module: number_analyzer_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the analyzer engine (2..8).
REQ-002 Parameter WIDTH, default 32, operand width in bits.
REQ-003 Parameter TIMEOUT, default 1024, maximum cycles to wait for engine completion (>=2).
REQ-004 Ports SHALL be listed one per line as below; clock and reset come first.
REQ-005 clock  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  N_REQ  per-requester request, held high until acknowledged.
REQ-008 req_number  input  N_REQ*WIDTH  per-requester operand; slice i is bits [i*WIDTH +: WIDTH].
REQ-009 req_ack  output  N_REQ  one-cycle grant pulse to the selected requester.
REQ-010 resp_valid  output  N_REQ  one-cycle response pulse to the served requester.
REQ-011 resp_result  output  1  analyzer verdict, valid with resp_valid.
REQ-012 resp_timeout  output  1  high with resp_valid when the engine did not finish in time.
REQ-013 eng_go  output  1  one-cycle start pulse to the analyzer engine.
REQ-014 eng_number  output  WIDTH  operand to engine; held stable from eng_go until the response.
REQ-015 eng_done  input  1  engine completion pulse.
REQ-016 eng_result  input  1  engine verdict, sampled when eng_done is high.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 timeout_count  output  8  saturating count of timed-out requests.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESPOND; all outputs registered.
REQ-020 IDLE: if any req_valid bit high, select winner by round-robin, latch its index and operand, go to ISSUE; else stay.
REQ-021 Round-robin: search starts at (last_grant+1) mod N_REQ, wraps, first set bit wins; after reset the search starts at index 0.
REQ-022 ISSUE (exactly one cycle): eng_go=1, req_ack[idx]=1, eng_number=latched operand; clear wait counter; go to WAIT.
REQ-023 WAIT: increment wait counter each cycle; on eng_done=1 latch eng_result, go to RESPOND with timeout flag 0.
REQ-024 WAIT: if counter reaches TIMEOUT-1 with eng_done low, go to RESPOND with result 0, timeout flag 1, and increment timeout_count (saturate at 255).
REQ-025 eng_done and timeout in the same cycle: eng_done wins; no timeout recorded.
REQ-026 eng_done outside WAIT SHALL be ignored.
REQ-027 RESPOND (exactly one cycle): resp_valid[idx]=1, resp_result and resp_timeout driven; update last_grant=idx; go to IDLE.
REQ-028 resp_result and resp_timeout hold their last values outside RESPOND; all other pulse outputs are 0 outside their state.
REQ-029 Minimum request-to-response: req_valid seen in IDLE at edge k -> req_ack/eng_go during k+1 -> resp_valid no earlier than k+3.
REQ-030 A req_valid deasserted before the sampling edge in IDLE SHALL not be granted; req_valid changes after grant do not affect the operation in flight.
REQ-031 Only one request in flight at a time; at most one bit of req_ack and of resp_valid is ever high.

Reset
REQ-032 reset high at a clock edge forces IDLE, last_grant pointer to N_REQ-1 (so index 0 searched first), wait counter 0, timeout_count 0.
REQ-033 During and after reset: req_ack, resp_valid, eng_go, resp_result, resp_timeout, busy = 0; eng_number = 0.
REQ-034 Reset mid-operation aborts the request with no response; the aborted requester must re-request.

Verification
REQ-035 Single request: req_valid=0001, number=13; engine done 5 cycles after eng_go with result 1 -> req_ack=0001 once, eng_number=13, resp_valid=0001 with result 1, timeout 0.
REQ-036 Fairness: req_valid=1111 held, each requester re-requests immediately -> grant order 0,1,2,3,0,1 exactly.
REQ-037 Timeout: TIMEOUT=8, engine never asserts done -> resp_valid pulse 8 cycles after entering WAIT with result 0, timeout 1, timeout_count=1; 300 timeouts -> timeout_count=255.
REQ-038 Collision: eng_done on the final WAIT cycle -> resp_timeout 0, result = eng_result, timeout_count unchanged.
REQ-039 Reset mid-WAIT: reset for 1 cycle -> no resp_valid, busy=0 next cycle, next grant goes to lowest pending index.
REQ-040 Stray eng_done in IDLE or ISSUE -> no state change, no response.
